// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ clients share a single i2c_master.
// Ports: clk, rst_n; client req_*/rsp_*; busy; master-side m_* handshake.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_rw,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 m_start,
    output logic [6:0]           m_slave_addr,
    output logic [7:0]           m_data_in,
    output logic                 m_rw,
    input  logic [7:0]           m_data_out,
    input  logic                 m_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t               state, state_n;
    logic [PW-1:0]        rr_ptr, rr_ptr_n;
    logic [PW-1:0]        owner, owner_n;
    logic [TW-1:0]        timer, timer_n;
    logic [NUM_REQ-1:0]   req_ready_n, rsp_valid_n;
    logic [7:0]           rsp_data_n;
    logic                 rsp_timeout_n;
    logic                 m_start_n;
    logic [6:0]           m_slave_addr_n;
    logic [7:0]           m_data_in_n;
    logic                 m_rw_n;

    logic                 found;
    logic [PW-1:0]        winner;
    logic [PW:0]          idx;
    logic [PW-1:0]        sel;
    logic [6:0]           win_addr;
    logic [7:0]           win_data;
    logic                 win_rw;

    // First valid client scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = '0;
        sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ)) begin
                idx = idx - (PW+1)'(NUM_REQ);
            end
            sel = idx[PW-1:0];
            if (!found && req_valid[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_rw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) begin
                win_addr = req_addr[7*i +: 7];
                win_data = req_data[8*i +: 8];
                win_rw   = req_rw[i];
            end
        end
    end

    always_comb begin
        state_n        = state;
        rr_ptr_n       = rr_ptr;
        owner_n        = owner;
        timer_n        = timer;
        req_ready_n    = '0;
        rsp_valid_n    = '0;
        m_start_n      = 1'b0;
        rsp_data_n     = rsp_data;
        rsp_timeout_n  = rsp_timeout;
        m_slave_addr_n = m_slave_addr;
        m_data_in_n    = m_data_in;
        m_rw_n         = m_rw;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n        = winner;
                    m_slave_addr_n = win_addr;
                    m_data_in_n    = win_data;
                    m_rw_n         = win_rw;
                    req_ready_n    = NUM_REQ'(1) << winner;
                    m_start_n      = 1'b1;
                    state_n        = START;
                end
            end
            START: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                timer_n = timer + 1'b1;
                // A done arriving on the timeout cycle still counts as success.
                if (m_done) begin
                    rsp_data_n    = m_data_out;
                    rsp_timeout_n = 1'b0;
                    rsp_valid_n   = NUM_REQ'(1) << owner;
                    state_n       = RESP;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_n    = '0;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = NUM_REQ'(1) << owner;
                    state_n       = RESP;
                end
            end
            RESP: begin
                rr_ptr_n = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            timer        <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            busy         <= 1'b0;
            m_start      <= 1'b0;
            m_slave_addr <= '0;
            m_data_in    <= '0;
            m_rw         <= 1'b0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            owner        <= owner_n;
            timer        <= timer_n;
            req_ready    <= req_ready_n;
            rsp_valid    <= rsp_valid_n;
            rsp_data     <= rsp_data_n;
            rsp_timeout  <= rsp_timeout_n;
            busy         <= (state_n != IDLE);
            m_start      <= m_start_n;
            m_slave_addr <= m_slave_addr_n;
            m_data_in    <= m_data_in_n;
            m_rw         <= m_rw_n;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter with a mock i2c_master.
// Stimulus rounds are modelled as round-robin service over per-client budgets.
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int TW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_rw = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_timeout;
    logic           busy;
    logic           m_start;
    logic [6:0]     m_slave_addr;
    logic [7:0]     m_data_in;
    logic           m_rw;
    logic [7:0]     m_data_out;
    logic           m_done;
    logic           mock_done = 1'b0;
    logic           stray_done = 1'b0;

    i2c_req_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(T),
        .TW(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_rw(req_rw),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .m_start(m_start),
        .m_slave_addr(m_slave_addr),
        .m_data_in(m_data_in),
        .m_rw(m_rw),
        .m_data_out(m_data_out),
        .m_done(m_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Mock slave: read byte is a fixed function of the slave address,
    // completion delay is a fixed function of the write byte (0xFF never ends).
    function automatic logic [7:0] slave_byte(input logic [6:0] a);
        return {a, 1'b1} ^ 8'hC3;
    endfunction

    function automatic int delay_of(input logic [7:0] d);
        if (d == 8'hFF) return -1;
        return int'(d) % 20 + 1;
    endfunction

    assign m_data_out = slave_byte(m_slave_addr);
    assign m_done     = mock_done | stray_done;

    int cnt = -1;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mock_done = 1'b0;
            if (!rst_n) begin
                cnt = -1;
            end else if (m_start) begin
                cnt = delay_of(m_data_in);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mock_done = 1'b1;
            end
        end
    end

    typedef struct {
        int         c;
        logic [6:0] a;
        logic [7:0] d;
        logic       rw;
        logic [7:0] rd;
        logic       to;
        int         lat;
    } txn_t;

    txn_t gq[$];
    txn_t rq[$];
    int   sq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   rr_m = 0;

    int         bud[N];
    logic [6:0] pa[N][4];
    logic [7:0] pd[N][4];
    logic       pr[N][4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    txn_t mg, mr;
    int   ms;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (req_ready != '0 || m_start) begin
                chk("start_with_ready", 32'(m_start), 32'(|req_ready));
            end
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 0);
                end else begin
                    mg = gq.pop_front();
                    chk("grant_client", 32'(req_ready), 32'(1) << mg.c);
                    chk("m_slave_addr", 32'(m_slave_addr), 32'(mg.a));
                    chk("m_data_in", 32'(m_data_in), 32'(mg.d));
                    chk("m_rw", 32'(m_rw), 32'(mg.rw));
                    sq.push_back(cyc);
                end
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0 || sq.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    mr = rq.pop_front();
                    ms = sq.pop_front();
                    chk("rsp_client", 32'(rsp_valid), 32'(1) << mr.c);
                    chk("rsp_data", 32'(rsp_data), 32'(mr.rd));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(mr.to));
                    chk("rsp_latency", 32'(cyc - ms), 32'(mr.lat));
                end
            end
        end
    end

    task automatic set_payload(input int i, input int k);
        req_addr[7*i +: 7] = pa[i][k];
        req_data[8*i +: 8] = pd[i][k];
        req_rw[i]          = pr[i][k];
    endtask

    task automatic run_round();
        int   rem[N];
        int   k[N];
        int   rr, left, idx, d, to;
        bit   got;
        txn_t t;
        left = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = bud[i];
            k[i]   = 0;
            left  += bud[i];
        end
        rr = rr_m;
        while (left > 0) begin
            got = 1'b0;
            idx = 0;
            for (int j = 0; j < N; j++) begin
                if (!got && rem[(rr + j) % N] > 0) begin
                    got = 1'b1;
                    idx = (rr + j) % N;
                end
            end
            t.c  = idx;
            t.a  = pa[idx][bud[idx] - rem[idx]];
            t.d  = pd[idx][bud[idx] - rem[idx]];
            t.rw = pr[idx][bud[idx] - rem[idx]];
            d    = delay_of(t.d);
            t.to  = (d < 1 || d > T);
            t.rd  = t.to ? 8'h00 : slave_byte(t.a);
            t.lat = t.to ? T + 1 : d + 1;
            gq.push_back(t);
            rq.push_back(t);
            rem[idx]--;
            left--;
            rr = (idx + 1) % N;
        end
        rr_m = rr;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (bud[i] > 0) begin
                set_payload(i, 0);
                req_valid[i] = 1'b1;
            end
        end
        to = 0;
        while (rq.size() > 0 && to < 3000) begin
            @(posedge clk);
            #1;
            to++;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    k[i]++;
                    if (k[i] < bud[i]) set_payload(i, k[i]);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        chk("round_drained", 32'(rq.size()), 0);
        if (rq.size() > 0) begin
            req_valid = '0;
            gq.delete();
            rq.delete();
            sq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_round();
        for (int i = 0; i < N; i++) begin
            bud[i] = 0;
            for (int k = 0; k < 4; k++) begin
                pa[i][k] = 7'($urandom);
                pd[i][k] = 8'($urandom);
                pr[i][k] = 1'($urandom);
            end
        end
    endtask

    task automatic random_round();
        int s;
        clear_round();
        s = 0;
        for (int i = 0; i < N; i++) begin
            bud[i] = $urandom_range(0, 3);
            s += bud[i];
        end
        if (s == 0) bud[$urandom_range(0, N-1)] = 1;
        run_round();
    endtask

    initial begin
        int to;
        #12;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_m_operands", {m_rw, m_slave_addr, m_data_in}, 0);
        #5;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Two simultaneous readers: client 0 first, then client 2.
        clear_round();
        bud[0] = 1; pa[0][0] = 7'h21; pd[0][0] = 8'h07; pr[0][0] = 1'b1;
        bud[2] = 1; pa[2][0] = 7'h33; pd[2][0] = 8'h0B; pr[2][0] = 1'b1;
        run_round();

        // Single writer on client 1.
        clear_round();
        bud[1] = 1; pa[1][0] = 7'h50; pd[1][0] = 8'hA5; pr[1][0] = 1'b0;
        run_round();

        // Slave never finishes: timeout, then a normal transaction.
        clear_round();
        bud[3] = 1; pa[3][0] = 7'h44; pd[3][0] = 8'hFF; pr[3][0] = 1'b1;
        run_round();
        clear_round();
        bud[3] = 1; pa[3][0] = 7'h45; pd[3][0] = 8'h02; pr[3][0] = 1'b1;
        run_round();

        // Done lands exactly on the last allowed cycle.
        clear_round();
        bud[0] = 1; pa[0][0] = 7'h12; pd[0][0] = 8'h0F; pr[0][0] = 1'b1;
        run_round();
        // One cycle too late: treated as timeout.
        clear_round();
        bud[1] = 1; pa[1][0] = 7'h13; pd[1][0] = 8'h10; pr[1][0] = 1'b1;
        run_round();

        for (int r = 0; r < 20; r++) random_round();

        // Reset in the middle of a transaction.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req_addr[14 +: 7] = 7'h11;
        req_data[16 +: 8] = 8'hFF;
        req_rw[2]         = 1'b0;
        req_valid[2]      = 1'b1;
        to = 0;
        while (!m_start && to < 100) begin
            @(posedge clk);
            #1;
            to++;
        end
        chk("rst_txn_started", 32'(m_start), 1);
        req_valid[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_wait", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_m_start", 32'(m_start), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_operands", {m_rw, m_slave_addr, m_data_in}, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stray_rsp_valid", 32'(rsp_valid), 0);
            chk("stray_busy", 32'(busy), 0);
        end
        rr_m = 0;
        gq.delete();
        rq.delete();
        sq.delete();
        mon_en = 1'b1;

        // All clients keep requesting: order 0,1,2,3,0,1.
        clear_round();
        bud[0] = 2; bud[1] = 2; bud[2] = 1; bud[3] = 1;
        run_round();

        for (int r = 0; r < 6; r++) random_round();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
